noc_switch_arbiter: RTL and testbench
=====================================

Name: noc_switch_arbiter

Overview:
- Packet-level arbiter and sequencer for one NoC switch slice.
- Shares the switch datapath between two requesters: self (the lower subarray) and right (the upstream neighbour).
- Locks the grant for a whole packet (one index flit followed by DATA_FLITS_PER_PKT data flits) and routes the packet to the self or left output from the switch-ID field of the index flit.
- Holds a one-flit registered output stage with downstream backpressure and round-robin fairness.

Parameters:
- GOLOBAL_DATA_BUS_WIDTH, 32, flit width.
- LAYER_ID_WIDTH, 4, layer-ID field width at the top of the index flit.
- SWITCH_ID_WIDTH, 6, switch-ID field width directly below the layer ID.
- THIS_SWITCH_ID, 0, ID that routes a packet to selfOut.
- DATA_FLITS_PER_PKT, 2, data flits after the index flit (range 1..255).
- TIMEOUT_CYCLES, 16, stall limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- selfReq  in  1  self requester has a flit valid
- selfData  in  GOLOBAL_DATA_BUS_WIDTH  self flit
- rightReq  in  1  right requester has a flit valid
- rightData  in  GOLOBAL_DATA_BUS_WIDTH  right flit
- grant2self  out  1  self flit is consumed this cycle
- grant2right  out  1  right flit is consumed this cycle
- selfOutputReq  out  1  output flit valid toward self
- selfOut  out  GOLOBAL_DATA_BUS_WIDTH  flit toward self; 0 when not valid
- selfOutputAck  in  1  self sink accepts flit
- leftOutputReq  out  1  output flit valid toward left
- leftOut  out  GOLOBAL_DATA_BUS_WIDTH  flit toward left; 0 when not valid
- leftOutputAck  in  1  left sink accepts flit
- busy  out  1  FSM not in IDLE
- pktAbort  out  1  one-cycle abort pulse; tied 0 unless the optional feature is compiled in

Behaviour:
- Switch-ID field = index flit bits [W-1-LAYER_ID_WIDTH : W-LAYER_ID_WIDTH-SWITCH_ID_WIDTH].
- Reset (reset=0, asynchronous):
  - FSM=IDLE, owner=self, rrPtr=self (self has priority first), flit counter=0, outValid=0.
  - All outputs 0.
- FSM states:
  - IDLE:
    - If exactly one Req is high, that side becomes owner.
    - If both are high, the side named by rrPtr becomes owner.
    - Next state INDEX. No grant is issued in IDLE.
  - INDEX:
    - Grant is issued when ownerReq=1 and the slot is free (see Output stage).
    - On grant: flit loads into the output register; dest=SELF if the switch-ID field equals THIS_SWITCH_ID, else LEFT. Counter=0. Next state DATA.
  - DATA:
    - Each grant loads the flit with the same dest and increments the counter.
    - On the grant with counter==DATA_FLITS_PER_PKT-1: next state IDLE and rrPtr toggles to the non-owner.
- Grant generation:
  - grant2self = (state INDEX or DATA) & owner==self & selfReq & slotFree.
  - grant2right is the same form for right.
  - Grants are mutually exclusive.
- Output stage:
  - selfOutputReq = outValid & dest==SELF; leftOutputReq = outValid & dest==LEFT.
  - The flit drains on Req&Ack for its direction.
  - slotFree = !outValid | draining this cycle (a back-to-back flit every cycle is legal).
  - outValid stays set while the sink holds Ack=0; data stays stable.
- Latency: Req rising in IDLE at cycle 0 -> grant at cycle 1 -> outputReq at cycle 2.
- Owner Req low mid-packet: no grant, state held, counter held. The non-owner is never granted until the packet completes.
- Non-owner Req during a packet: ignored; it wins the next IDLE arbitration through rrPtr.
- Reset asserted mid-packet: all state cleared immediately; the partial packet is dropped and outputs go to 0.
- Counter width: 8 bits.

Optional Feature:
- Macro: NOC_ARB_TIMEOUT_EN.
- Enabled:
  - A stall counter counts consecutive INDEX/DATA cycles with ownerReq=0, and clears on any grant.
  - When it reaches TIMEOUT_CYCLES: pktAbort pulses for 1 cycle, FSM goes to IDLE and rrPtr toggles.
  - A flit already in the output register still drains normally.
- Disabled: no stall counter; pktAbort is tied 0; the FSM waits indefinitely.

Test Plan:
- Defaults with THIS_SWITCH_ID=3, Acks tied 1; selfReq held with flits 32'h00C0_0000, 32'hAAAA_0001, 32'hAAAA_0002 -> grant2self cycles 1-3; selfOutputReq cycles 2-4 carrying those flits; leftOutputReq stays 0; busy falls after cycle 3.
- Same setup, rightReq with index 32'h0100_0000 (switch ID 4) -> three flits appear on leftOut; selfOut stays 0.
- selfReq and rightReq both high from reset -> self packet first, then right; repeat -> self again (round-robin alternation).
- leftOutputAck=0 for 5 cycles during a right packet -> leftOut held stable; no grant2right while the slot is full; packet resumes once Ack=1.
- reset driven low while in DATA after the index flit -> all outputs 0 asynchronously; after release, a new self packet completes normally.
- NOC_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16; owner Req drops after the index flit -> pktAbort pulses on the 16th stalled cycle; FSM returns to IDLE and the other requester wins next.

Source files
------------

// File: rtl/noc_switch_arbiter.sv
// noc_switch_arbiter: packet-level arbiter/sequencer for one NoC switch slice.
// Two requesters (self, right) share a one-flit registered output stage that
// feeds either the self or the left output. The grant is locked for a whole
// packet (index flit + DATA_FLITS_PER_PKT data flits). Ownership alternates
// round-robin between packets when both sides compete.
// Optional stall timeout: compile with `define NOC_ARB_TIMEOUT_EN.
module noc_switch_arbiter #(
    parameter int unsigned GOLOBAL_DATA_BUS_WIDTH = 32,
    parameter int unsigned LAYER_ID_WIDTH         = 4,
    parameter int unsigned SWITCH_ID_WIDTH        = 6,
    parameter int unsigned THIS_SWITCH_ID         = 0,
    parameter int unsigned DATA_FLITS_PER_PKT     = 2,
    parameter int unsigned TIMEOUT_CYCLES         = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              selfReq,
    input  logic [GOLOBAL_DATA_BUS_WIDTH-1:0] selfData,
    input  logic                              rightReq,
    input  logic [GOLOBAL_DATA_BUS_WIDTH-1:0] rightData,
    output logic                              grant2self,
    output logic                              grant2right,
    output logic                              selfOutputReq,
    output logic [GOLOBAL_DATA_BUS_WIDTH-1:0] selfOut,
    input  logic                              selfOutputAck,
    output logic                              leftOutputReq,
    output logic [GOLOBAL_DATA_BUS_WIDTH-1:0] leftOut,
    input  logic                              leftOutputAck,
    output logic                              busy,
    output logic                              pktAbort
);

    localparam int unsigned W      = GOLOBAL_DATA_BUS_WIDTH;
    localparam int unsigned SID_HI = W - 1 - LAYER_ID_WIDTH;
    localparam int unsigned SID_LO = W - LAYER_ID_WIDTH - SWITCH_ID_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INDEX,
        ST_DATA
    } state_t;

    typedef enum logic {
        SIDE_SELF,
        SIDE_RIGHT
    } side_t;

    typedef enum logic {
        DEST_SELF,
        DEST_LEFT
    } dest_t;

    state_t       state, next_state;
    side_t        owner, next_owner;
    side_t        rr_ptr, next_rr;
    side_t        other_side;
    logic [7:0]   flit_cnt, next_cnt;

    logic         out_valid;
    logic [W-1:0] out_data;
    dest_t        dest;
    dest_t        idx_dest;

    logic         owner_req;
    logic [W-1:0] owner_data;
    logic         drain;
    logic         slot_free;
    logic         grant;
    logic         last_flit;
    logic         stall_abort;

    // State register: FSM, owner, round-robin pointer and flit counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            owner    <= SIDE_SELF;
            rr_ptr   <= SIDE_SELF;
            flit_cnt <= '0;
        end else begin
            state    <= next_state;
            owner    <= next_owner;
            rr_ptr   <= next_rr;
            flit_cnt <= next_cnt;
        end
    end

    // Output stage register: load on grant, clear when drained with nothing new
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            dest      <= DEST_SELF;
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data  <= owner_data;
            if (state == ST_INDEX) begin
                dest <= idx_dest;
            end
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

`ifdef NOC_ARB_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_cnt;

    // Stall counter: consecutive in-packet cycles with the owner request low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (state == ST_IDLE || owner_req || stall_abort) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    // Abort fires on the stalled cycle that completes the limit
    always_comb begin
        stall_abort = (state != ST_IDLE) && !owner_req &&
                      (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
    end
`else
    logic unused_timeout_cfg;

    // Without the stall counter the FSM waits indefinitely for the owner
    always_comb begin
        stall_abort        = 1'b0;
        unused_timeout_cfg = ^TIMEOUT_CYCLES;
    end
`endif

    // Next-state logic: arbitration in IDLE, packet sequencing in INDEX/DATA
    always_comb begin
        next_state = state;
        next_owner = owner;
        next_rr    = rr_ptr;
        next_cnt   = flit_cnt;
        case (state)
            ST_IDLE: begin
                if (selfReq && rightReq) begin
                    next_owner = rr_ptr;
                    next_state = ST_INDEX;
                end else if (selfReq) begin
                    next_owner = SIDE_SELF;
                    next_state = ST_INDEX;
                end else if (rightReq) begin
                    next_owner = SIDE_RIGHT;
                    next_state = ST_INDEX;
                end
            end
            ST_INDEX: begin
                if (grant) begin
                    next_cnt   = '0;
                    next_state = ST_DATA;
                end else if (stall_abort) begin
                    next_state = ST_IDLE;
                    next_rr    = other_side;
                end
            end
            ST_DATA: begin
                if (grant) begin
                    if (last_flit) begin
                        next_cnt   = '0;
                        next_state = ST_IDLE;
                        next_rr    = other_side;
                    end else begin
                        next_cnt = flit_cnt + 8'd1;
                    end
                end else if (stall_abort) begin
                    next_state = ST_IDLE;
                    next_rr    = other_side;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Output logic: grants, destination decode and gated output flits
    always_comb begin
        other_side    = (owner == SIDE_SELF) ? SIDE_RIGHT : SIDE_SELF;
        owner_req     = (owner == SIDE_SELF) ? selfReq : rightReq;
        owner_data    = (owner == SIDE_SELF) ? selfData : rightData;
        idx_dest      = (owner_data[SID_HI:SID_LO] == SWITCH_ID_WIDTH'(THIS_SWITCH_ID))
                        ? DEST_SELF : DEST_LEFT;
        last_flit     = (flit_cnt == 8'(DATA_FLITS_PER_PKT - 1));

        selfOutputReq = out_valid && (dest == DEST_SELF);
        leftOutputReq = out_valid && (dest == DEST_LEFT);
        drain         = (selfOutputReq && selfOutputAck) ||
                        (leftOutputReq && leftOutputAck);
        slot_free     = !out_valid || drain;

        grant         = (state != ST_IDLE) && owner_req && slot_free;
        grant2self    = grant && (owner == SIDE_SELF);
        grant2right   = grant && (owner == SIDE_RIGHT);

        selfOut       = selfOutputReq ? out_data : '0;
        leftOut       = leftOutputReq ? out_data : '0;
        busy          = (state != ST_IDLE);
        pktAbort      = stall_abort;
    end

endmodule

// File: tb/tb_noc_switch_arbiter.sv
// Directed bench for noc_switch_arbiter (THIS_SWITCH_ID=3, default widths).
// A vector table covers single-source packets to both outputs and round-robin
// alternation; hand-written sequences cover backpressure, asynchronous reset
// mid-packet and owner stalls (with or without NOC_ARB_TIMEOUT_EN).
module tb_noc_switch_arbiter;

    localparam int W = 32;
    localparam logic [W-1:0] IS = 32'h00C0_0000; // index, switch ID 3 -> self
    localparam logic [W-1:0] IR = 32'h0100_0000; // index, switch ID 4 -> left

    logic         clk = 1'b0;
    logic         reset;
    logic         selfReq, rightReq;
    logic [W-1:0] selfData, rightData;
    logic         grant2self, grant2right;
    logic         selfOutputReq, leftOutputReq;
    logic [W-1:0] selfOut, leftOut;
    logic         selfOutputAck, leftOutputAck;
    logic         busy, pktAbort;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    noc_switch_arbiter #(
        .THIS_SWITCH_ID (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .selfReq       (selfReq),
        .selfData      (selfData),
        .rightReq      (rightReq),
        .rightData     (rightData),
        .grant2self    (grant2self),
        .grant2right   (grant2right),
        .selfOutputReq (selfOutputReq),
        .selfOut       (selfOut),
        .selfOutputAck (selfOutputAck),
        .leftOutputReq (leftOutputReq),
        .leftOut       (leftOut),
        .leftOutputAck (leftOutputAck),
        .busy          (busy),
        .pktAbort      (pktAbort)
    );

    // flags = {grant2self, grant2right, selfOutputReq, leftOutputReq, busy, pktAbort}
    typedef struct {
        string        name;
        logic         s_req;
        logic [W-1:0] s_data;
        logic         r_req;
        logic [W-1:0] r_data;
        logic         s_ack;
        logic         l_ack;
        logic [5:0]   flags;
        logic [W-1:0] sout;
        logic [W-1:0] lout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string name, logic s_req, logic [W-1:0] s_data,
                                logic r_req, logic [W-1:0] r_data,
                                logic s_ack, logic l_ack, logic [5:0] flags,
                                logic [W-1:0] sout, logic [W-1:0] lout);
        vec_t v;
        v.name = name;   v.s_req = s_req; v.s_data = s_data;
        v.r_req = r_req; v.r_data = r_data;
        v.s_ack = s_ack; v.l_ack = l_ack;
        v.flags = flags; v.sout = sout;   v.lout = lout;
        return v;
    endfunction

    task automatic check(string name, logic [5:0] ef, logic [W-1:0] es, logic [W-1:0] el);
        logic [5:0] af;
        af = {grant2self, grant2right, selfOutputReq, leftOutputReq, busy, pktAbort};
        tests++;
        if (af !== ef || selfOut !== es || leftOut !== el) begin
            fails++;
            $display("FAIL %s: got flags(gs,gr,sreq,lreq,busy,abort)=%b selfOut=%h leftOut=%h, want flags=%b selfOut=%h leftOut=%h",
                     name, af, selfOut, leftOut, ef, es, el);
        end
    endtask

    task automatic drive(vec_t v);
        selfReq       = v.s_req;
        selfData      = v.s_data;
        rightReq      = v.r_req;
        rightData     = v.r_data;
        selfOutputAck = v.s_ack;
        leftOutputAck = v.l_ack;
    endtask

    // One cycle: inputs change at the falling edge, outputs sampled just before the rising edge
    task automatic apply(vec_t v);
        @(negedge clk);
        drive(v);
        #4;
        check(v.name, v.flags, v.sout, v.lout);
    endtask

    initial begin
        // Reset state, with requests active to show nothing leaks through
        reset = 1'b0;
        drive(mk("init", 1, IS, 1, IR, 1, 1, 6'b0, '0, '0));
        #12;
        check("reset_state", 6'b000000, '0, '0);
        drive(mk("init", 0, '0, 0, '0, 1, 1, 6'b0, '0, '0));
        @(negedge clk);
        reset = 1'b1;

        // Self packet to selfOut
        tbl.push_back(mk("s_idle",     1, IS,           0, '0, 1, 1, 6'b000000, '0, '0));
        tbl.push_back(mk("s_idx_gnt",  1, IS,           0, '0, 1, 1, 6'b100010, '0, '0));
        tbl.push_back(mk("s_d1",       1, 32'hAAAA0001, 0, '0, 1, 1, 6'b101010, IS, '0));
        tbl.push_back(mk("s_d2",       1, 32'hAAAA0002, 0, '0, 1, 1, 6'b101010, 32'hAAAA0001, '0));
        tbl.push_back(mk("s_tail",     0, '0,           0, '0, 1, 1, 6'b001000, 32'hAAAA0002, '0));
        tbl.push_back(mk("s_quiet",    0, '0,           0, '0, 1, 1, 6'b000000, '0, '0));
        // Right packet to leftOut
        tbl.push_back(mk("r_idle",     0, '0, 1, IR,           1, 1, 6'b000000, '0, '0));
        tbl.push_back(mk("r_idx_gnt",  0, '0, 1, IR,           1, 1, 6'b010010, '0, '0));
        tbl.push_back(mk("r_d1",       0, '0, 1, 32'hBBBB0001, 1, 1, 6'b010110, '0, IR));
        tbl.push_back(mk("r_d2",       0, '0, 1, 32'hBBBB0002, 1, 1, 6'b010110, '0, 32'hBBBB0001));
        tbl.push_back(mk("r_tail",     0, '0, 0, '0,           1, 1, 6'b000100, '0, 32'hBBBB0002));
        tbl.push_back(mk("r_quiet",    0, '0, 0, '0,           1, 1, 6'b000000, '0, '0));
        // Both competing: self, right, self
        tbl.push_back(mk("rr_idle",    1, IS,           1, IR,           1, 1, 6'b000000, '0, '0));
        tbl.push_back(mk("rr_s_idx",   1, IS,           1, IR,           1, 1, 6'b100010, '0, '0));
        tbl.push_back(mk("rr_s_d1",    1, 32'hAAAA0003, 1, IR,           1, 1, 6'b101010, IS, '0));
        tbl.push_back(mk("rr_s_d2",    1, 32'hAAAA0004, 1, IR,           1, 1, 6'b101010, 32'hAAAA0003, '0));
        tbl.push_back(mk("rr_arb_r",   1, IS,           1, IR,           1, 1, 6'b001000, 32'hAAAA0004, '0));
        tbl.push_back(mk("rr_r_idx",   1, IS,           1, IR,           1, 1, 6'b010010, '0, '0));
        tbl.push_back(mk("rr_r_d1",    1, IS,           1, 32'hBBBB0003, 1, 1, 6'b010110, '0, IR));
        tbl.push_back(mk("rr_r_d2",    1, IS,           1, 32'hBBBB0004, 1, 1, 6'b010110, '0, 32'hBBBB0003));
        tbl.push_back(mk("rr_arb_s",   1, IS,           1, IR,           1, 1, 6'b000100, '0, 32'hBBBB0004));
        tbl.push_back(mk("rr_s2_idx",  1, IS,           1, IR,           1, 1, 6'b100010, '0, '0));
        tbl.push_back(mk("rr_s2_d1",   1, 32'hAAAA0005, 0, '0,           1, 1, 6'b101010, IS, '0));
        tbl.push_back(mk("rr_s2_d2",   1, 32'hAAAA0006, 0, '0,           1, 1, 6'b101010, 32'hAAAA0005, '0));
        tbl.push_back(mk("rr_s2_tail", 0, '0,           0, '0,           1, 1, 6'b001000, 32'hAAAA0006, '0));
        tbl.push_back(mk("rr_quiet",   0, '0,           0, '0,           1, 1, 6'b000000, '0, '0));

        foreach (tbl[i]) apply(tbl[i]);

        // Backpressure on the left sink during a right packet
        apply(mk("bp_idle",  0, '0, 1, IR, 1, 1, 6'b000000, '0, '0));
        apply(mk("bp_idx",   0, '0, 1, IR, 1, 1, 6'b010010, '0, '0));
        for (int i = 0; i < 5; i++)
            apply(mk("bp_hold", 0, '0, 1, 32'hBBBB0011, 1, 0, 6'b000110, '0, IR));
        apply(mk("bp_rel",   0, '0, 1, 32'hBBBB0011, 1, 1, 6'b010110, '0, IR));
        apply(mk("bp_d2",    0, '0, 1, 32'hBBBB0012, 1, 1, 6'b010110, '0, 32'hBBBB0011));
        apply(mk("bp_tail",  0, '0, 0, '0,           1, 1, 6'b000100, '0, 32'hBBBB0012));
        apply(mk("bp_quiet", 0, '0, 0, '0,           1, 1, 6'b000000, '0, '0));

        // Asynchronous reset in the middle of a self packet
        apply(mk("mr_idle", 1, IS,           0, '0, 1, 1, 6'b000000, '0, '0));
        apply(mk("mr_idx",  1, IS,           0, '0, 1, 1, 6'b100010, '0, '0));
        apply(mk("mr_d1",   1, 32'hAAAA0021, 0, '0, 1, 1, 6'b101010, IS, '0));
        @(negedge clk);
        drive(mk("mr_d2", 1, 32'hAAAA0022, 0, '0, 1, 1, 6'b0, '0, '0));
        #2;
        check("mr_pre_reset", 6'b101010, 32'hAAAA0021, '0);
        #1;
        reset = 1'b0;
        #1;
        check("mr_async_clear", 6'b000000, '0, '0);
        @(negedge clk);
        check("mr_reset_hold", 6'b000000, '0, '0);
        drive(mk("mr_rel", 0, '0, 0, '0, 1, 1, 6'b0, '0, '0));
        reset = 1'b1;
        apply(mk("mr_n_idle", 1, IS,           0, '0, 1, 1, 6'b000000, '0, '0));
        apply(mk("mr_n_idx",  1, IS,           0, '0, 1, 1, 6'b100010, '0, '0));
        apply(mk("mr_n_d1",   1, 32'hAAAA0031, 0, '0, 1, 1, 6'b101010, IS, '0));
        apply(mk("mr_n_d2",   1, 32'hAAAA0032, 0, '0, 1, 1, 6'b101010, 32'hAAAA0031, '0));
        apply(mk("mr_n_tail", 0, '0,           0, '0, 1, 1, 6'b001000, 32'hAAAA0032, '0));
        apply(mk("mr_n_quiet",0, '0,           0, '0, 1, 1, 6'b000000, '0, '0));

        // Owner (right) drops its request after the index flit; self keeps requesting
        apply(mk("st_idle",  0, '0, 1, IR, 1, 1, 6'b000000, '0, '0));
        apply(mk("st_idx",   0, '0, 1, IR, 1, 1, 6'b010010, '0, '0));
        apply(mk("st_first", 1, IS, 0, '0, 1, 1, 6'b000110, '0, IR));
`ifdef NOC_ARB_TIMEOUT_EN
        for (int i = 0; i < 14; i++)
            apply(mk("to_stall", 1, IS, 0, '0, 1, 1, 6'b000010, '0, '0));
        apply(mk("to_abort",     1, IS, 0, '0, 1, 1, 6'b000011, '0, '0));
        apply(mk("to_idle",      1, IS, 0, '0, 1, 1, 6'b000000, '0, '0));
        apply(mk("to_self_wins", 1, IS, 0, '0, 1, 1, 6'b100010, '0, '0));
`else
        for (int i = 0; i < 20; i++)
            apply(mk("st_wait", 1, IS, 0, '0, 1, 1, 6'b000010, '0, '0));
        apply(mk("st_resume",    1, IS, 1, 32'hBBBB0041, 1, 1, 6'b010010, '0, '0));
        apply(mk("st_last",      1, IS, 1, 32'hBBBB0042, 1, 1, 6'b010110, '0, 32'hBBBB0041));
        apply(mk("st_tail",      1, IS, 0, '0,           1, 1, 6'b000100, '0, 32'hBBBB0042));
        apply(mk("st_self_wins", 1, IS, 0, '0,           1, 1, 6'b100010, '0, '0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
